vis_byte_framer: RTL and testbench
==================================

# vis_byte_framer

Downstream stage of `toy_correlator`; sits in the `bus_clock` domain. Consumes the correlator's visibility stream (`bus_revis`/`bus_imvis`, valid/ready/last) into a small FIFO and serialises each visibility frame into an 8-bit valid/ready/last byte stream for the host link (UART/SPI bridge). Each frame on the output gets a 4-byte header (two sync bytes, 16-bit sequence number) followed by every visibility as 8 little-endian bytes.

## Interface
- `WIDTH`, 32 — bits per real/imag word (matches correlator `ACCUM`); fixed 32 in this revision.
- `ABITS`, 5 — FIFO address bits; depth = 2^ABITS entries.
- `SYNC0`, 8'hA5 — first header byte.
- `SYNC1`, 8'h5A — second header byte.

- `bus_clock`  in  1  sole clock; all logic rising-edge.
- `bus_reset`  in  1  synchronous, active-high reset.
- `bus_revis_i`  in  WIDTH  real part of visibility.
- `bus_imvis_i`  in  WIDTH  imaginary part.
- `bus_valid_i`  in  1  input entry valid.
- `bus_ready_o`  out  1  input ready (FIFO not full).
- `bus_last_i`  in  1  final entry of a visibility frame.
- `byte_data_o`  out  8  output byte.
- `byte_valid_o`  out  1  output byte valid.
- `byte_ready_i`  in  1  downstream accepts byte.
- `byte_last_o`  out  1  final byte of a frame.
- `frame_seq_o`  out  16  sequence number of the next frame to be emitted.
- `level_o`  out  ABITS+1  FIFO occupancy.

## Operation
- FIFO entry = {last, im, re} (2·WIDTH+1 bits). Push when `bus_valid_i && bus_ready_o`. `bus_ready_o = !full`; no push while full, so push-at-full is impossible. Never drops data.
- Push and pop in the same cycle are both allowed when 0 < level < depth; level unchanged.
- FSM states:
  - IDLE: byte_valid_o=0. If FIFO non-empty, load `SYNC0` into the output register, assert valid, go to HDR.
  - HDR: bytes SYNC0, SYNC1, seq[7:0], seq[15:8]. Advance on handshake. After seq[15:8] handshakes, pop the head entry into an 64-bit shift register, present re[7:0], go to DATA. The FIFO is guaranteed non-empty here because no pop occurs in IDLE/HDR.
  - DATA: bytes re[7:0]..re[31:24], im[7:0]..im[31:24] (byte counter 0–7). On the handshake of byte 7: if the entry's last=1, increment seq (wrap 16'hFFFF→0) and go to IDLE. Otherwise, if the FIFO is non-empty, pop the next entry and present its byte 0 in the next cycle with no bubble; else drop valid and wait in DATA until an entry arrives.
- `byte_last_o` = 1 only on byte 7 of an entry whose last flag is set.
- Once asserted, `byte_valid_o` and `byte_data_o` stay stable until the handshake (AXI-S rule).
- `frame_seq_o` updates in the cycle after the final-byte handshake.

## Timing
- Reset values: `bus_ready_o`=0, `byte_valid_o`=0, `byte_last_o`=0, `byte_data_o`=8'h00, `frame_seq_o`=0, `level_o`=0, FSM=IDLE, FIFO empty.
- `bus_ready_o` rises in the first cycle after reset deasserts.
- Push at edge k makes the FIFO non-empty at k; IDLE sees this and raises `byte_valid_o` with SYNC0 after edge k+1. First-byte latency is 2 cycles.
- Sustained rate is 1 byte/cycle while `byte_ready_i`=1. The frame for N entries takes 4+8N cycles.
- Reset mid-frame aborts the frame. There is no partial completion; the FIFO is flushed and seq is cleared.
- A frame whose entries arrive slower than they drain has gaps (valid low) inside DATA only, never inside HDR.

## Structure
- Shared package `vis_pkg`: WIDTH constant, SYNC0/SYNC1 values, the FSM state enum, and the header length (4) and bytes-per-entry (8) constants.
- One sub-module: `sync_fifo` (single clock, sync active-high reset, parameters DATA_W and ABITS, with full/empty/level outputs). Instantiate it with DATA_W = 2·WIDTH+1.

## Test plan
- Single entry: re=32'h04030201, im=32'h08070605, last=1, ready held high. Required output: A5 5A 00 00 01 02 03 04 05 06 07 08, last on 08, and `frame_seq_o` becomes 1.
- Three-entry frame followed by a second frame. Required: 28 bytes and then 28 bytes, the second header carrying seq 01 00, and exactly two `byte_last_o` pulses.
- Backpressure: random `byte_ready_i` at 30% duty. Required: byte sequence identical to the run without backpressure; data and valid stable while stalled.
- Fill: hold `byte_ready_i`=0 and push until full. Required: `bus_ready_o`=0 at level 32, no data loss, and all 32 entries drained in order afterwards.
- Seq wrap: preload 65535 frames, or force-start at seq 16'hFFFF via a fast loop. Required: header bytes FF FF, then 00 00 on the next frame.
- Reset asserted during DATA byte 3. Required: all outputs return to reset values the next cycle, level 0, and a subsequent frame begins with seq 00 00.

Source files
------------

// File: rtl/vis_pkg.sv
// Shared constants and FSM encoding for the visibility byte framer.
// Header is two sync bytes plus a little-endian 16-bit sequence number.
package vis_pkg;

    localparam int         VIS_WIDTH   = 32;
    localparam logic [7:0] VIS_SYNC0   = 8'hA5;
    localparam logic [7:0] VIS_SYNC1   = 8'h5A;
    localparam int         HDR_LEN     = 4;
    localparam int         ENTRY_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is read
// asynchronously so a pop can load its consumer in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 65,
    parameter int ABITS  = 5
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ABITS:0]    level
);

    localparam int DEPTH = 1 << ABITS;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ABITS-1:0]  wr_ptr_reg;
    logic [ABITS-1:0]  rd_ptr_reg;
    logic [ABITS:0]    level_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (level_reg == (ABITS+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;

endmodule

// File: rtl/vis_byte_framer.sv
// Buffers correlator visibilities and serialises each frame as
// SYNC0 SYNC1 seq_lo seq_hi followed by 8 little-endian bytes per entry.
module vis_byte_framer
    import vis_pkg::*;
#(
    parameter int         WIDTH = VIS_WIDTH,
    parameter int         ABITS = 5,
    parameter logic [7:0] SYNC0 = VIS_SYNC0,
    parameter logic [7:0] SYNC1 = VIS_SYNC1
) (
    input  logic             bus_clock,
    input  logic             bus_reset,
    input  logic [WIDTH-1:0] bus_revis_i,
    input  logic [WIDTH-1:0] bus_imvis_i,
    input  logic             bus_valid_i,
    output logic             bus_ready_o,
    input  logic             bus_last_i,
    output logic [7:0]       byte_data_o,
    output logic             byte_valid_o,
    input  logic             byte_ready_i,
    output logic             byte_last_o,
    output logic [15:0]      frame_seq_o,
    output logic [ABITS:0]   level_o
);

    localparam int ENTRY_W = 2*WIDTH + 1;

    logic               ready_en_reg;
    logic               push;
    logic               pop;
    logic               load;
    logic               xfer;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] shift_reg, shift_next;
    logic               elast_reg, elast_next;
    logic [15:0]        seq_reg, seq_next;
    logic [7:0]         data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               last_reg, last_next;

    // Ready is held low for the cycle after reset so upstream never pushes into a flushing FIFO.
    always_ff @(posedge bus_clock) begin
        if (bus_reset) ready_en_reg <= 1'b0;
        else           ready_en_reg <= 1'b1;
    end

    assign bus_ready_o = ready_en_reg && !fifo_full;
    assign push        = bus_valid_i && bus_ready_o;

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .ABITS  (ABITS)
    ) u_fifo (
        .clk     (bus_clock),
        .srst    (bus_reset),
        .wr_en   (push),
        .wr_data ({bus_last_i, bus_imvis_i, bus_revis_i}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

    always_ff @(posedge bus_clock) begin
        if (bus_reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            elast_reg <= 1'b0;
            seq_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            elast_reg <= elast_next;
            seq_reg   <= seq_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        elast_next = elast_reg;
        seq_next   = seq_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        load       = 1'b0;
        pop        = 1'b0;
        xfer       = valid_reg && byte_ready_i;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    data_next  = SYNC0;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    cnt_next = cnt_reg + 3'd1;
                    case (cnt_reg)
                        3'd0:    data_next = SYNC1;
                        3'd1:    data_next = seq_reg[7:0];
                        3'd2:    data_next = seq_reg[15:8];
                        default: load = 1'b1;
                    endcase
                    if (cnt_reg == 3'(HDR_LEN-1)) state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (cnt_reg == 3'(ENTRY_BYTES-1)) begin
                        last_next = 1'b0;
                        if (elast_reg) begin
                            seq_next   = seq_reg + 16'd1;
                            valid_next = 1'b0;
                            state_next = ST_IDLE;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            valid_next = 1'b0;
                        end
                    end else begin
                        shift_next = shift_reg >> 8;
                        data_next  = shift_reg[15:8];
                        cnt_next   = cnt_reg + 3'd1;
                        last_next  = elast_reg && (cnt_reg == 3'(ENTRY_BYTES-2));
                    end
                end else if (!valid_reg && !fifo_empty) begin
                    // Starved mid-frame: resume as soon as the next entry lands.
                    load = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            pop        = 1'b1;
            shift_next = fifo_rd[2*WIDTH-1:0];
            elast_next = fifo_rd[2*WIDTH];
            data_next  = fifo_rd[7:0];
            valid_next = 1'b1;
            last_next  = 1'b0;
            cnt_next   = '0;
        end
    end

    always_comb begin
        byte_data_o  = data_reg;
        byte_valid_o = valid_reg;
        byte_last_o  = last_reg;
        frame_seq_o  = seq_reg;
    end

endmodule

// File: tb/tb_vis_byte_framer.sv
// Scoreboard bench: a frame-level model queues expected bytes at push time,
// a monitor pops and compares on every output handshake.
module tb_vis_byte_framer;

    logic        bus_clock = 1'b0;
    logic        bus_reset;
    logic [31:0] bus_revis_i;
    logic [31:0] bus_imvis_i;
    logic        bus_valid_i;
    logic        bus_ready_o;
    logic        bus_last_i;
    logic [7:0]  byte_data_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic        byte_last_o;
    logic [15:0] frame_seq_o;
    logic [5:0]  level_o;

    always #5 bus_clock = ~bus_clock;

    vis_byte_framer dut (
        .bus_clock    (bus_clock),
        .bus_reset    (bus_reset),
        .bus_revis_i  (bus_revis_i),
        .bus_imvis_i  (bus_imvis_i),
        .bus_valid_i  (bus_valid_i),
        .bus_ready_o  (bus_ready_o),
        .bus_last_i   (bus_last_i),
        .byte_data_o  (byte_data_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_last_o  (byte_last_o),
        .frame_seq_o  (frame_seq_o),
        .level_o      (level_o)
    );

    int          checks = 0;
    int          passes = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] model_seq = 16'd0;
    bit          in_frame = 1'b0;
    int          ready_mode = 0;   // 0: hold low, 1: hold high, 2: 30% random
    int          last_count = 0;
    bit          stalled = 1'b0;
    logic [7:0]  stall_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reference: a frame is header(seq) then each entry's {im,re} as 8 LE bytes.
    task automatic model_push(input logic [31:0] re, input logic [31:0] im, input logic last);
        logic [63:0] w;
        w = {im, re};
        if (!in_frame) begin
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, 8'h5A});
            exp_q.push_back({1'b0, model_seq[7:0]});
            exp_q.push_back({1'b0, model_seq[15:8]});
            in_frame = 1'b1;
        end
        for (int b = 0; b < 8; b++) exp_q.push_back({last && (b == 7), w[8*b +: 8]});
        if (last) begin
            model_seq = model_seq + 16'd1;
            in_frame  = 1'b0;
        end
    endtask

    always @(negedge bus_clock) begin
        case (ready_mode)
            0:       byte_ready_i = 1'b0;
            1:       byte_ready_i = 1'b1;
            default: byte_ready_i = ($urandom_range(0, 99) < 30);
        endcase
    end

    always @(negedge bus_clock) begin
        logic [8:0] e;
        #1;
        if (bus_reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {byte_valid_o, byte_data_o}, {1'b1, stall_data});
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL byte_unexpected: got %h last %b, required no byte", byte_data_o, byte_last_o);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {byte_last_o, byte_data_o}, e);
                    $display("byte %h last %b", byte_data_o, byte_last_o);
                end
                if (byte_last_o) last_count++;
                stalled = 1'b0;
            end else if (byte_valid_o) begin
                stalled    = 1'b1;
                stall_data = byte_data_o;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_entry(input logic [31:0] re, input logic [31:0] im, input logic last);
        int t;
        t = 0;
        @(negedge bus_clock);
        bus_revis_i = re;
        bus_imvis_i = im;
        bus_last_i  = last;
        bus_valid_i = 1'b1;
        while (!bus_ready_o && t < 2000) begin
            @(negedge bus_clock);
            t++;
        end
        if (!bus_ready_o) begin
            checks++;
            $display("FAIL push_timeout: got bus_ready_o 0, required 1");
        end else begin
            model_push(re, im, last);
        end
        @(posedge bus_clock);
        #1;
        bus_valid_i = 1'b0;
    endtask

    task automatic push_frame(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            push_entry($urandom, $urandom, i == n - 1);
            repeat ($urandom_range(0, max_gap)) @(negedge bus_clock);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || byte_valid_o) && t < 5000) begin
            @(negedge bus_clock);
            t++;
        end
        @(negedge bus_clock);
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge bus_clock);
        bus_reset   = 1'b1;
        bus_valid_i = 1'b0;
        exp_q.delete();
        model_seq = 16'd0;
        in_frame  = 1'b0;
        repeat (2) @(negedge bus_clock);
        bus_reset = 1'b0;
        @(negedge bus_clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0;
        int t;
        bus_reset   = 1'b1;
        bus_valid_i = 1'b0;
        bus_revis_i = '0;
        bus_imvis_i = '0;
        bus_last_i  = 1'b0;
        repeat (3) @(negedge bus_clock);
        check("rst_bus_ready", bus_ready_o, 0);
        check("rst_valid", byte_valid_o, 0);
        check("rst_last", byte_last_o, 0);
        check("rst_data", byte_data_o, 0);
        check("rst_seq", frame_seq_o, 0);
        check("rst_level", level_o, 0);
        bus_reset = 1'b0;
        @(negedge bus_clock);
        check("ready_after_rst", bus_ready_o, 1);

        // Single entry, fixed values, with first-byte latency.
        ready_mode = 1;
        lc0 = last_count;
        push_entry(32'h04030201, 32'h08070605, 1'b1);
        @(negedge bus_clock);
        check("latency_k", byte_valid_o, 0);
        @(negedge bus_clock);
        check("latency_k1", {byte_valid_o, byte_data_o}, {1'b1, 8'hA5});
        wait_drain();
        check("single_seq", frame_seq_o, 1);
        check("single_lasts", last_count - lc0, 1);

        // Two three-entry frames.
        do_reset();
        ready_mode = 1;
        lc0 = last_count;
        push_frame(3, 0);
        push_frame(3, 0);
        wait_drain();
        check("two_frame_lasts", last_count - lc0, 2);
        check("two_frame_seq", frame_seq_o, 2);

        // Backpressure with irregular arrival.
        ready_mode = 2;
        for (int f = 0; f < 5; f++) push_frame($urandom_range(1, 4), 12);
        wait_drain();
        check("bp_seq", frame_seq_o, 7);

        // Fill the FIFO while the link is stalled.
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 32; i++) push_entry($urandom, $urandom, i == 31);
        check("fill_level", level_o, 32);
        check("fill_ready", bus_ready_o, 0);
        @(negedge bus_clock);
        bus_revis_i = 32'hDEADBEEF;
        bus_valid_i = 1'b1;
        repeat (3) @(negedge bus_clock);
        check("full_hold_level", level_o, 32);
        bus_valid_i = 1'b0;
        ready_mode = 1;
        wait_drain();
        check("drained_level", level_o, 0);

        // Sequence wrap from 16'hFFFF.
        force dut.seq_reg = 16'hFFFF;
        model_seq = 16'hFFFF;
        @(negedge bus_clock);
        release dut.seq_reg;
        @(negedge bus_clock);
        check("forced_seq", frame_seq_o, 16'hFFFF);
        push_frame(1, 0);
        push_frame(2, 0);
        wait_drain();
        check("wrap_seq", frame_seq_o, 1);

        // Reset in the middle of DATA byte 3.
        ready_mode = 1;
        push_entry(32'h44332211, 32'h88776655, 1'b1);
        t = 0;
        while (!(byte_valid_o && byte_data_o == 8'h44) && t < 50) begin
            @(negedge bus_clock);
            t++;
        end
        check("reached_byte3", {byte_valid_o, byte_data_o}, {1'b1, 8'h44});
        bus_reset = 1'b1;
        exp_q.delete();
        model_seq = 16'd0;
        in_frame  = 1'b0;
        @(negedge bus_clock);
        check("midrst_valid", byte_valid_o, 0);
        check("midrst_last", byte_last_o, 0);
        check("midrst_data", byte_data_o, 0);
        check("midrst_seq", frame_seq_o, 0);
        check("midrst_level", level_o, 0);
        check("midrst_ready", bus_ready_o, 0);
        bus_reset = 1'b0;
        @(negedge bus_clock);
        push_frame(2, 0);
        wait_drain();
        check("post_rst_seq", frame_seq_o, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
